// File: rtl/tm_rau_pkg.sv
// Shared widths, one-hot state encoding and the latched launch request
// bundle for the thread-manager launch stage in front of RAU.
package tm_rau_pkg;

  localparam int NUM_HW_WARPS = 8;
  localparam int SLOT_W       = $clog2(NUM_HW_WARPS);
  localparam int SWWARP_W     = 32;
  localparam int NREQ_W       = 3;
  localparam int EFF_W        = NREQ_W + 1;
  localparam int AVAIL_W      = 5;
  localparam int CNT_W        = EFF_W;
  localparam int ALLO_SLACK   = 2;

  localparam int B_IDLE  = 0;
  localparam int B_CHECK = 1;
  localparam int B_ISSUE = 2;
  localparam int B_WAIT  = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CHECK = 4'b0010,
    S_ISSUE = 4'b0100,
    S_WAIT  = 4'b1000
  } tm_state_e;

  typedef struct packed {
    logic [SWWARP_W-1:0] swwarp;
    logic [NREQ_W-1:0]   nreq;
    logic [SLOT_W-1:0]   slot;
  } tm_req_t;

  // RAU hands out registers in pairs, so odd requests round up.
  function automatic logic [EFF_W-1:0] nreq_eff(
    input logic [NREQ_W-1:0] n
  );
    return {1'b0, n} + EFF_W'(n[0]);
  endfunction

  // One RAU cycle per register pair plus the READY/ALLO hops.
  function automatic logic [CNT_W-1:0] wait_cnt(
    input logic [EFF_W-1:0] e
  );
    return CNT_W'(e >> 1) + CNT_W'(ALLO_SLACK);
  endfunction

endpackage

// File: rtl/tm_free_slot_enc.sv
// Lowest-zero priority encoder over the active-slot bitmap.
// Ports: active (bitmap) -> any_free, idx (lowest free slot).
module tm_free_slot_enc
  import tm_rau_pkg::*;
(
  input  logic [NUM_HW_WARPS-1:0] active,
  output logic                    any_free,
  output logic [SLOT_W-1:0]       idx
);

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    any_free = 1'b0;
    idx      = '0;
    for (int i = NUM_HW_WARPS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        any_free = 1'b1;
        idx      = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/tm_warp_launch.sv
// TM launch stage: picks a free HW slot, requests RAU allocation,
// waits it out, marks the slot active; snoops/stalls IB exits.
// Ports: Launch_* handshake, TM_RAU_* request, IB exit snoop/stall,
// TM_WarpActive bitmap, sticky TM_Err.
module tm_warp_launch
  import tm_rau_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Launch_Valid,
  output logic                    Launch_Ready,
  input  logic [SWWARP_W-1:0]     Launch_SWWarp,
  input  logic [NREQ_W-1:0]       Launch_Nreq,
  output logic                    Launch_Done,
  output logic [SLOT_W-1:0]       Launch_HWWarp,
  input  logic [AVAIL_W-1:0]      RAU_TM_Available,
  output logic                    TM_RAU_AlloEN,
  output logic [NREQ_W-1:0]       TM_RAU_Nreq,
  output logic [SLOT_W-1:0]       TM_RAU_HWWarp,
  output logic [SWWARP_W-1:0]     TM_RAU_SWWarp,
  input  logic                    IB_RAU_ExitEN,
  input  logic [SLOT_W-1:0]       IB_Exit_WarpID,
  output logic                    TM_IB_ExitStall,
  output logic [NUM_HW_WARPS-1:0] TM_WarpActive,
  output logic                    TM_Err
);

  tm_state_e               state;
  tm_state_e               state_nx;
  tm_req_t                 req;
  logic [NUM_HW_WARPS-1:0] active;
  logic [CNT_W-1:0]        cnt;
  logic                    exit_d;
  logic                    err;

  logic                    any_free;
  logic [SLOT_W-1:0]       free_idx;
  logic [EFF_W-1:0]        eff;
  logic                    fits;
  logic                    ready;
  logic                    stall;
  logic                    allo;
  logic                    done;
  logic                    accept;
  logic                    exit_take;

  tm_free_slot_enc u_enc (
    .active   (active),
    .any_free (any_free),
    .idx      (free_idx)
  );

  assign eff  = nreq_eff(req.nreq);
  assign fits = AVAIL_W'(eff) <= RAU_TM_Available;

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    stall    = 1'b0;
    allo     = 1'b0;
    done     = 1'b0;
    unique case (1'b1)
      state[B_IDLE]: begin
        ready = any_free && !IB_RAU_ExitEN;
        if (Launch_Valid && ready) state_nx = S_CHECK;
      end
      state[B_CHECK]: begin
        // Around an exit RAU is deallocating and Available is stale.
        if (fits && !IB_RAU_ExitEN && !exit_d) state_nx = S_ISSUE;
      end
      state[B_ISSUE]: begin
        allo     = 1'b1;
        stall    = 1'b1;
        state_nx = S_WAIT;
      end
      state[B_WAIT]: begin
        stall = 1'b1;
        if (cnt == '0) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept    = Launch_Valid && ready;
  assign exit_take = IB_RAU_ExitEN && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      req    <= '0;
      active <= '0;
      cnt    <= '0;
      exit_d <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      exit_d <= exit_take;
      if (accept) begin
        req.swwarp <= Launch_SWWarp;
        req.nreq   <= Launch_Nreq;
        req.slot   <= free_idx;
      end
      if (state == S_ISSUE) begin
        cnt <= wait_cnt(eff);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Set and clear never coincide: exits are stalled in WAIT.
      if (done) active[req.slot] <= 1'b1;
      if (exit_take) begin
        if (active[IB_Exit_WarpID]) active[IB_Exit_WarpID] <= 1'b0;
        else                        err <= 1'b1;
      end
    end
  end

  assign Launch_Ready    = ready;
  assign Launch_Done     = done;
  assign Launch_HWWarp   = req.slot;
  assign TM_RAU_AlloEN   = allo;
  assign TM_RAU_Nreq     = req.nreq;
  assign TM_RAU_HWWarp   = req.slot;
  assign TM_RAU_SWWarp   = req.swwarp;
  assign TM_IB_ExitStall = stall;
  assign TM_WarpActive   = active;
  assign TM_Err          = err;

endmodule
